// File: rtl/k_dsp_execute.sv
// k_dsp_execute: two-stage execute pipeline (S1 operand/product, S2 result)
// with ALU, signed multiply and saturating multiply-accumulate.
//
// Handshake: a transfer happens on a rising edge where valid && ready on
// that side. Both stages advance together when adv = !out_valid || out_ready,
// and in_ready is adv itself, so a stalled result also freezes S1. Nothing
// that is valid is ever dropped or duplicated by a stall.
module k_dsp_execute #(
  parameter int ACC_W = 48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  opcode,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        acc_sat
);

  typedef enum logic [2:0] {
    OP_ADD     = 3'd0,
    OP_SUB     = 3'd1,
    OP_MUL     = 3'd2,
    OP_MAC     = 3'd3,
    OP_ACC_CLR = 3'd4,
    OP_ACC_RD  = 3'd5
  } op_e;

  // Sum width: wide enough to hold any accumulator plus any 64-bit product
  // without wrapping, so the clamp decision is always exact.
  localparam int SW = 66;

  localparam logic signed [SW-1:0] ACC_MAX = {{(SW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [SW-1:0] ACC_MIN = {{(SW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

  // Clamp a signed accumulator value into the signed 32-bit range.
  function automatic logic [31:0] sat32(input logic [ACC_W-1:0] x);
    logic [ACC_W-32:0] hi;
    hi = x[ACC_W-1:31];
    if (hi == '0 || hi == '1) return x[31:0];
    else if (x[ACC_W-1])      return 32'h8000_0000;
    else                      return 32'h7FFF_FFFF;
  endfunction

  logic adv;

  // S1 registers
  logic        s1_valid_q;
  logic [2:0]  s1_op_q;
  logic [31:0] s1_a_q, s1_b_q;
  logic [63:0] s1_prod_q;
  logic [63:0] prod_d;

  // S2 / architectural state
  logic             out_valid_q;
  logic [31:0]      result_q, res_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             sat_q, sat_d;

  logic signed [SW-1:0] acc_ext, prod_ext, mac_sum;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign acc_sat   = sat_q;

  // Full 64-bit signed product from sign-extended operands.
  assign prod_d = {{32{rs1[31]}}, rs1} * {{32{rs2[31]}}, rs2};

  assign acc_ext  = {{(SW-ACC_W){acc_q[ACC_W-1]}}, acc_q};
  assign prod_ext = {{(SW-64){s1_prod_q[63]}}, s1_prod_q};
  assign mac_sum  = acc_ext + prod_ext;

  // S1: capture operands, opcode and product whenever the pipe advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_prod_q  <= '0;
    end else if (adv) begin
      s1_valid_q <= in_valid;
      s1_op_q    <= opcode;
      s1_a_q     <= rs1;
      s1_b_q     <= rs2;
      s1_prod_q  <= prod_d;
    end
  end

  // S2 next state: result and accumulator update for the op leaving S1.
  always_comb begin
    res_d = result_q;
    acc_d = acc_q;
    sat_d = sat_q;
    if (s1_valid_q) begin
      case (s1_op_q)
        OP_ADD: res_d = s1_a_q + s1_b_q;
        OP_SUB: res_d = s1_a_q - s1_b_q;
        OP_MUL: res_d = s1_prod_q[31:0];
        OP_MAC: begin
          if (mac_sum > ACC_MAX) begin
            acc_d = ACC_MAX[ACC_W-1:0];
            sat_d = 1'b1;
          end else if (mac_sum < ACC_MIN) begin
            acc_d = ACC_MIN[ACC_W-1:0];
            sat_d = 1'b1;
          end else begin
            acc_d = mac_sum[ACC_W-1:0];
          end
          res_d = sat32(acc_d);
        end
        OP_ACC_CLR: begin
          res_d = sat32(acc_q);
          acc_d = '0;
          sat_d = 1'b0;
        end
        OP_ACC_RD: res_d = sat32(acc_q);
        default:   res_d = '0;
      endcase
    end
  end

  // S2 register: only moves on adv, so a stalled S1 op commits exactly once.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      acc_q       <= '0;
      sat_q       <= 1'b0;
    end else if (adv) begin
      out_valid_q <= s1_valid_q;
      result_q    <= res_d;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
    end
  end

endmodule
